// File: rtl/w5300_pkg.sv
// Shared constants for the W5300 socket-0 bus responder.
// Addresses are byte addresses on the 8-bit host bus.
package w5300_pkg;

    localparam logic [9:0] A_IR_MSB  = 10'h002;
    localparam logic [9:0] A_IR_LSB  = 10'h003;
    localparam logic [9:0] A_S0_CR   = 10'h203;
    localparam logic [9:0] A_S0_IMR  = 10'h205;
    localparam logic [9:0] A_S0_IR   = 10'h207;
    localparam logic [9:0] A_TX_MSB  = 10'h22E;
    localparam logic [9:0] A_TX_LSB  = 10'h22F;
    localparam logic [9:0] A_RX_MSB  = 10'h230;
    localparam logic [9:0] A_RX_LSB  = 10'h231;

    // 32-bit registers decoded on addr[9:2]
    localparam logic [7:0] G_TX_WRSR = 8'h88;
    localparam logic [7:0] G_TX_FSR  = 8'h89;
    localparam logic [7:0] G_RX_RSR  = 8'h8A;

    localparam logic [7:0] CR_SEND   = 8'h20;
    localparam logic [7:0] CR_RECV   = 8'h40;

    localparam int IR_SENDOK = 4;
    localparam int IR_RECV   = 2;

    typedef enum logic {
        SEND_IDLE,
        SEND_BUSY
    } send_state_e;

    function automatic logic [7:0] be_byte(
        input logic [31:0] v,
        input logic [1:0]  idx
    );
        case (idx)
            2'd0:    return v[31:24];
            2'd1:    return v[23:16];
            2'd2:    return v[15:8];
            default: return v[7:0];
        endcase
    endfunction

endpackage

// File: rtl/w5300_rx_fifo.sv
// RX packet word FIFO; push and pop may occur in the same cycle.
module w5300_rx_fifo #(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [15:0]   din,
    input  logic          pop,
    output logic [15:0]   dout,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PONE  = AW'(1);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PONE;
            if (do_pop)  rd_ptr <= rd_ptr + PONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CONE;
                2'b01:   count <= count - CONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/w5300_bus_responder.sv
// W5300 8-bit host bus responder emulating socket 0 registers,
// an RX packet FIFO, a TX word stream and the SEND/RECV interrupts.
module w5300_bus_responder
    import w5300_pkg::*;
#(
    parameter int          RX_DEPTH   = 64,
    parameter logic [31:0] FSR_RESET  = 32'h0000_2000,
    parameter int          SEND_DELAY = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  addr,
    input  logic        cs_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        int_n,
    input  logic        rx_valid,
    input  logic        rx_last,
    input  logic [15:0] rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [15:0] tx_data
);

    localparam int CW = $clog2(RX_DEPTH) + 1;
    localparam logic [CW-1:0] RX_FULL = CW'(RX_DEPTH);

    logic          cs_q, rd_q, wr_q;
    logic [9:0]    addr_q, acc_addr;
    logic [7:0]    din_q, w_data;
    logic          rd_act, wr_act, rd_act_d, wr_act_d;
    logic          wr_commit, rd_end, wr_cr, tx_push, pop_req;
    logic          push_ok, pop_ok, rx_empty, busy, send_done, s0_int;
    logic [7:0]    imr, ir, ir_set, ir_clr, tx_msb, rd_mux;
    logic [31:0]   wrsr, fsr, rsr;
    logic [15:0]   rx_head, send_cnt;
    logic [CW-1:0] rx_count, cnt_nxt;
    send_state_e   state;

    assign rd_act    = !cs_q && !rd_q;
    assign wr_act    = !cs_q && !wr_q;
    // accesses take effect once the strobe has gone away
    assign wr_commit = wr_act_d && !wr_act;
    assign rd_end    = rd_act_d && !rd_act;
    assign wr_cr     = wr_commit && (acc_addr == A_S0_CR);
    assign tx_push   = wr_commit && (acc_addr == A_TX_LSB) && (fsr != '0);
    assign pop_req   = rd_end && (acc_addr == A_RX_LSB);

    assign rx_empty  = (rx_count == '0);
    assign push_ok   = rx_valid && rx_ready;
    assign pop_ok    = pop_req && !rx_empty;
    assign cnt_nxt   = rx_count + CW'(push_ok) - CW'(pop_ok);
    assign rsr       = 32'({rx_count, 1'b0});

    assign busy      = (state == SEND_BUSY);
    assign send_done = busy && (send_cnt == 16'd1);
    assign s0_int    = |(ir & imr);
    assign ir_clr    = (wr_commit && acc_addr == A_S0_IR) ? w_data : 8'h00;

    always_comb begin
        ir_set            = 8'h00;
        ir_set[IR_SENDOK] = send_done;
        ir_set[IR_RECV]   = push_ok && rx_last;
    end

    always_comb begin
        rd_mux = 8'h00;
        unique case (1'b1)
            addr_q == A_IR_MSB:       rd_mux = 8'h00;
            addr_q == A_IR_LSB:       rd_mux = {7'b0, s0_int};
            addr_q == A_S0_CR:        rd_mux = busy ? CR_SEND : 8'h00;
            addr_q == A_S0_IMR:       rd_mux = imr;
            addr_q == A_S0_IR:        rd_mux = ir;
            addr_q[9:2] == G_TX_WRSR: rd_mux = be_byte(wrsr, addr_q[1:0]);
            addr_q[9:2] == G_TX_FSR:  rd_mux = be_byte(fsr, addr_q[1:0]);
            addr_q[9:2] == G_RX_RSR:  rd_mux = be_byte(rsr, addr_q[1:0]);
            addr_q == A_RX_MSB:       rd_mux = rx_empty ? 8'h00 : rx_head[15:8];
            addr_q == A_RX_LSB:       rd_mux = rx_empty ? 8'h00 : rx_head[7:0];
            default:                  rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q     <= 1'b1;
            rd_q     <= 1'b1;
            wr_q     <= 1'b1;
            addr_q   <= '0;
            din_q    <= '0;
            rd_act_d <= 1'b0;
            wr_act_d <= 1'b0;
            acc_addr <= '0;
            w_data   <= '0;
            data_oe  <= 1'b0;
            data_out <= '0;
        end else begin
            cs_q     <= cs_n;
            rd_q     <= rd_n;
            wr_q     <= wr_n;
            addr_q   <= addr;
            din_q    <= data_in;
            rd_act_d <= rd_act;
            wr_act_d <= wr_act;
            if (rd_act || wr_act) acc_addr <= addr_q;
            if (wr_act) w_data <= din_q;
            data_oe  <= rd_act;
            data_out <= rd_act ? rd_mux : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imr      <= 8'hFF;
            ir       <= '0;
            wrsr     <= '0;
            tx_msb   <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            int_n    <= 1'b1;
            rx_ready <= 1'b1;
        end else begin
            ir       <= (ir & ~ir_clr) | ir_set;
            int_n    <= ~s0_int;
            rx_ready <= (cnt_nxt != RX_FULL);
            tx_valid <= tx_push;
            if (tx_push) tx_data <= {tx_msb, w_data};
            if (wr_commit) begin
                if (acc_addr == A_S0_IMR) imr <= w_data;
                if (acc_addr == A_TX_MSB) tx_msb <= w_data;
                if (acc_addr[9:2] == G_TX_WRSR) begin
                    case (acc_addr[1:0])
                        2'd0:    wrsr[31:24] <= w_data;
                        2'd1:    wrsr[23:16] <= w_data;
                        2'd2:    wrsr[15:8]  <= w_data;
                        default: wrsr[7:0]   <= w_data;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEND_IDLE;
            send_cnt <= '0;
            fsr      <= FSR_RESET;
        end else begin
            if (tx_push) fsr <= fsr - 32'd2;
            unique case (state)
                SEND_IDLE: begin
                    if (wr_cr) begin
                        case (w_data)
                            CR_SEND: begin
                                send_cnt <= 16'(SEND_DELAY);
                                state    <= SEND_BUSY;
                            end
                            CR_RECV: ;
                            default: ;
                        endcase
                    end
                end
                SEND_BUSY: begin
                    send_cnt <= send_cnt - 16'd1;
                    if (send_cnt == 16'd1) begin
                        fsr   <= FSR_RESET;
                        state <= SEND_IDLE;
                    end
                end
            endcase
        end
    end

    w5300_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .din   (rx_data),
        .pop   (pop_req),
        .dout  (rx_head),
        .count (rx_count)
    );

endmodule

// File: tb/tb_w5300_bus_responder.sv
// Directed bench for w5300_bus_responder: bus reads/writes,
// RX stream, TX stream, SEND timing, masking, FIFO limits, reset.
module tb_w5300_bus_responder;

    localparam int DEPTH = 64;
    localparam int DLY   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  addr = '0;
    logic        cs_n = 1'b1;
    logic        rd_n = 1'b1;
    logic        wr_n = 1'b1;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        int_n;
    logic        rx_valid = 1'b0;
    logic        rx_last = 1'b0;
    logic [15:0] rx_data = '0;
    logic        rx_ready;
    logic        tx_valid;
    logic [15:0] tx_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          tx_cnt = 0;
    logic [15:0] tx_last = '0;

    always #5 clk = ~clk;

    w5300_bus_responder #(
        .RX_DEPTH   (DEPTH),
        .FSR_RESET  (32'h0000_2000),
        .SEND_DELAY (DLY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .cs_n     (cs_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .int_n    (int_n),
        .rx_valid (rx_valid),
        .rx_last  (rx_last),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data)
    );

    always @(negedge clk) begin
        if (tx_valid) begin
            tx_cnt++;
            tx_last = tx_data;
        end
    end

    task automatic bus_read(input logic [9:0] a, output logic [7:0] d);
        addr = a;
        cs_n = 1'b0;
        rd_n = 1'b0;
        repeat (3) @(negedge clk);
        d = data_out;
        cs_n = 1'b1;
        rd_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [7:0] v);
        addr = a;
        data_in = v;
        cs_n = 1'b0;
        wr_n = 1'b0;
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        wr_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic rx_push(input logic [15:0] w, input logic l);
        rx_valid = 1'b1;
        rx_data = w;
        rx_last = l;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_last = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic [9:0] ra [6] = '{10'h224, 10'h225, 10'h226, 10'h227, 10'h203, 10'h22B};
        logic [7:0] re [6] = '{8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({int_n, data_oe, rx_ready, tx_valid} !== 4'b1010) begin
            n_bad++;
            $display("FAIL reset_flags: int_n/oe/ready/txv=%b want 1010",
                     {int_n, data_oe, rx_ready, tx_valid});
        end
        n_cmp++;
        if ({data_out, tx_data} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_data: data_out=%h tx_data=%h want 00/0000",
                     data_out, tx_data);
        end
        for (int i = 0; i < 6; i++) begin
            bus_read(ra[i], d);
            n_cmp++;
            if (d !== re[i]) begin
                n_bad++;
                $display("FAIL reset_reg %h: got %h want %h", ra[i], d, re[i]);
            end
        end
    endtask

    task automatic test_rx_stream;
        logic [7:0] d;
        logic [9:0] ra [14] = '{10'h002, 10'h003, 10'h207, 10'h228, 10'h229,
                                10'h22A, 10'h22B, 10'h230, 10'h231, 10'h230,
                                10'h231, 10'h230, 10'h231, 10'h22B};
        logic [7:0] re [14] = '{8'h00, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00,
                                8'h06, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F,
                                8'h20, 8'h00};
        rx_push(16'h4845, 1'b0);
        rx_push(16'h4C4C, 1'b0);
        rx_push(16'h4F20, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (int_n !== 1'b0) begin
            n_bad++;
            $display("FAIL recv_int: int_n=%b want 0", int_n);
        end
        for (int i = 0; i < 14; i++) begin
            bus_read(ra[i], d);
            n_cmp++;
            if (d !== re[i]) begin
                n_bad++;
                $display("FAIL rx_read %0d @%h: got %h want %h", i, ra[i], d, re[i]);
            end
        end
    endtask

    task automatic test_recv_clear;
        logic [7:0] d;
        logic [9:0] ra [3] = '{10'h231, 10'h22B, 10'h207};
        bus_write(10'h207, 8'h04);
        n_cmp++;
        if (int_n !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_int_early: int_n=%b want 0", int_n);
        end
        @(negedge clk);
        n_cmp++;
        if (int_n !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_int: int_n=%b want 1", int_n);
        end
        for (int i = 0; i < 3; i++) begin
            bus_read(ra[i], d);
            n_cmp++;
            if (d !== 8'h00) begin
                n_bad++;
                $display("FAIL empty_read @%h: got %h want 00", ra[i], d);
            end
        end
    endtask

    task automatic test_tx;
        logic [7:0] d;
        int base;
        logic [7:0] re [4] = '{8'h00, 8'h00, 8'h1F, 8'hFE};
        base = tx_cnt;
        bus_write(10'h22E, 8'hC0);
        bus_write(10'h22F, 8'hA8);
        @(negedge clk);
        n_cmp++;
        if (tx_cnt - base !== 1 || tx_last !== 16'hC0A8) begin
            n_bad++;
            $display("FAIL tx_word: pulses=%0d data=%h want 1/C0A8",
                     tx_cnt - base, tx_last);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(10'h224 + 10'(i), d);
            n_cmp++;
            if (d !== re[i]) begin
                n_bad++;
                $display("FAIL tx_fsr byte %0d: got %h want %h", i, d, re[i]);
            end
        end
    endtask

    task automatic test_send;
        logic [7:0] d;
        logic [9:0] ra [6] = '{10'h207, 10'h224, 10'h225, 10'h226, 10'h227, 10'h203};
        logic [7:0] re [6] = '{8'h10, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00};
        bus_write(10'h203, 8'h20);
        bus_read(10'h203, d);
        n_cmp++;
        if (d !== 8'h20) begin
            n_bad++;
            $display("FAIL cr_pending: got %h want 20", d);
        end
        repeat (DLY - 5) @(negedge clk);
        n_cmp++;
        if (int_n !== 1'b1) begin
            n_bad++;
            $display("FAIL sendok_early: int_n=%b want 1", int_n);
        end
        @(negedge clk);
        n_cmp++;
        if (int_n !== 1'b0) begin
            n_bad++;
            $display("FAIL sendok_int: int_n=%b want 0", int_n);
        end
        for (int i = 0; i < 6; i++) begin
            bus_read(ra[i], d);
            n_cmp++;
            if (d !== re[i]) begin
                n_bad++;
                $display("FAIL send_reg @%h: got %h want %h", ra[i], d, re[i]);
            end
        end
        bus_write(10'h207, 8'h10);
        @(negedge clk);
        n_cmp++;
        if (int_n !== 1'b1) begin
            n_bad++;
            $display("FAIL sendok_clr: int_n=%b want 1", int_n);
        end
    endtask

    task automatic test_imr_mask;
        logic [7:0] d;
        logic [9:0] ra [4] = '{10'h207, 10'h230, 10'h231, 10'h205};
        logic [7:0] re [4] = '{8'h04, 8'h12, 8'h34, 8'h00};
        bus_write(10'h205, 8'h00);
        rx_push(16'h1234, 1'b1);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (int_n !== 1'b1) begin
            n_bad++;
            $display("FAIL masked_int: int_n=%b want 1", int_n);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(ra[i], d);
            n_cmp++;
            if (d !== re[i]) begin
                n_bad++;
                $display("FAIL mask_reg @%h: got %h want %h", ra[i], d, re[i]);
            end
        end
        bus_write(10'h207, 8'h04);
        bus_write(10'h205, 8'hFF);
    endtask

    task automatic test_wrsr;
        logic [7:0] d;
        logic [7:0] re [4] = '{8'h00, 8'h12, 8'h00, 8'h34};
        bus_write(10'h221, 8'h12);
        bus_write(10'h223, 8'h34);
        bus_write(10'h226, 8'h55);
        for (int i = 0; i < 4; i++) begin
            bus_read(10'h220 + 10'(i), d);
            n_cmp++;
            if (d !== re[i]) begin
                n_bad++;
                $display("FAIL wrsr byte %0d: got %h want %h", i, d, re[i]);
            end
        end
        bus_read(10'h226, d);
        n_cmp++;
        if (d !== 8'h20) begin
            n_bad++;
            $display("FAIL fsr_readonly: got %h want 20", d);
        end
    endtask

    task automatic test_fsr_drain;
        logic [7:0] d;
        int base;
        base = tx_cnt;
        for (int i = 0; i < 4096; i++) bus_write(10'h22F, 8'(i));
        @(negedge clk);
        n_cmp++;
        if (tx_cnt - base !== 4096) begin
            n_bad++;
            $display("FAIL drain_pulses: got %0d want 4096", tx_cnt - base);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(10'h224 + 10'(i), d);
            n_cmp++;
            if (d !== 8'h00) begin
                n_bad++;
                $display("FAIL drain_fsr byte %0d: got %h want 00", i, d);
            end
        end
        bus_write(10'h22F, 8'h77);
        @(negedge clk);
        n_cmp++;
        if (tx_cnt - base !== 4096) begin
            n_bad++;
            $display("FAIL drop_at_zero: pulses=%0d want 4096", tx_cnt - base);
        end
    endtask

    task automatic test_fifo_full;
        logic [7:0] d;
        for (int k = 0; k < DEPTH - 1; k++)
            rx_push({8'h80 + 8'(k), 8'h40 + 8'(k)}, 1'b0);
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_at_63: rx_ready=%b want 1", rx_ready);
        end
        rx_push({8'h80 + 8'(DEPTH - 1), 8'h40 + 8'(DEPTH - 1)}, 1'b0);
        n_cmp++;
        if (rx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_full: rx_ready=%b want 0", rx_ready);
        end
        rx_push(16'hFFFF, 1'b0);
        bus_read(10'h22B, d);
        n_cmp++;
        if (d !== 8'h80) begin
            n_bad++;
            $display("FAIL rsr_full: got %h want 80", d);
        end
        bus_read(10'h231, d);
        n_cmp++;
        if (d !== 8'h40 || rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL pop_full: data=%h ready=%b want 40/1", d, rx_ready);
        end
        // pop of word 1 lands on the same edge as a push
        addr = 10'h231;
        cs_n = 1'b0;
        rd_n = 1'b0;
        repeat (3) @(negedge clk);
        d = data_out;
        cs_n = 1'b1;
        rd_n = 1'b1;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = 16'hBEEF;
        @(negedge clk);
        rx_valid = 1'b0;
        n_cmp++;
        if (d !== 8'h41) begin
            n_bad++;
            $display("FAIL concurrent_pop_data: got %h want 41", d);
        end
        @(negedge clk);
        bus_read(10'h22B, d);
        n_cmp++;
        if (d !== 8'h7E) begin
            n_bad++;
            $display("FAIL concurrent_count: rsr=%h want 7E", d);
        end
    endtask

    task automatic test_reset_mid_read;
        logic [7:0] d;
        addr = 10'h230;
        cs_n = 1'b0;
        rd_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (data_oe !== 1'b1 || data_out !== 8'h82) begin
            n_bad++;
            $display("FAIL pre_reset_read: oe=%b data=%h want 1/82", data_oe, data_out);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({data_oe, rx_ready, int_n} !== 3'b011) begin
            n_bad++;
            $display("FAIL async_reset: oe/ready/int_n=%b want 011",
                     {data_oe, rx_ready, int_n});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (data_oe !== 1'b1 || data_out !== 8'h00) begin
            n_bad++;
            $display("FAIL post_reset_access: oe=%b data=%h want 1/00", data_oe, data_out);
        end
        cs_n = 1'b1;
        rd_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(10'h22B, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_fifo_empty: rsr=%h want 00", d);
        end
    endtask

    initial begin
        test_reset;
        test_rx_stream;
        test_recv_clear;
        test_tx;
        test_send;
        test_imr_mask;
        test_wrsr;
        test_fsr_drain;
        test_fifo_full;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
